// File: rtl/branch_history_unit_if.sv
// Shared prediction type and the fetch/resolve/table-update bus of the branch history unit.
package branch_history_unit_pkg;
    typedef enum logic [1:0] {
        snt = 2'b00,
        wnt = 2'b01,
        wt  = 2'b10,
        st  = 2'b11
    } prediction_t;
endpackage

interface branch_history_unit_if
    import branch_history_unit_pkg::*;
#(
    parameter int unsigned past_branch_bits = 2
);
    logic                        fetch_valid;
    logic [31:0]                 fetch_pc;
    prediction_t                 fetch_prediction;
    logic                        fetch_ready;
    logic                        resolve_valid;
    logic                        resolve_taken;
    logic [31:0]                 resolve_target;
    logic [past_branch_bits-1:0] past_branches;
    logic                        update;
    logic                        correct;
    logic [31:0]                 pc_update;
    logic [31:0]                 calculated_target;
    prediction_t                 previous_prediction;
    logic [past_branch_bits-1:0] update_history;
    logic                        mispredict;
    logic [31:0]                 mispredict_count;
    logic [31:0]                 resolve_count;

    // Core side: issues fetches and resolutions, consumes table updates.
    modport master (
        output fetch_valid, fetch_pc, fetch_prediction,
        output resolve_valid, resolve_taken, resolve_target,
        input  fetch_ready, past_branches, update, correct, pc_update,
        input  calculated_target, previous_prediction, update_history,
        input  mispredict, mispredict_count, resolve_count
    );

    // History unit side.
    modport slave (
        input  fetch_valid, fetch_pc, fetch_prediction,
        input  resolve_valid, resolve_taken, resolve_target,
        output fetch_ready, past_branches, update, correct, pc_update,
        output calculated_target, previous_prediction, update_history,
        output mispredict, mispredict_count, resolve_count
    );
endinterface

// File: rtl/branch_history_unit.sv
// Speculative global history plus in-order record FIFO of in-flight predicted branches.
// Optional statistics counters enabled by defining BHU_STATS_EN.
module branch_history_unit
    import branch_history_unit_pkg::*;
#(
    parameter int unsigned past_branch_bits = 2,
    parameter int unsigned depth            = 4
) (
    input logic                  clk,
    input logic                  rst,
    branch_history_unit_if.slave bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;

    logic [31:0]                 pc_mem   [depth];
    prediction_t                 pred_mem [depth];
    logic [past_branch_bits-1:0] hist_mem [depth];

    logic [ptr_w-1:0]            wr_ptr;
    logic [ptr_w-1:0]            rd_ptr;
    logic [cnt_w-1:0]            count;
    logic [cnt_w-1:0]            count_next;
    logic [past_branch_bits-1:0] ghr;

    logic        pop;
    logic        push;
    logic        flush;
    logic        pop_correct;
    logic [31:0] head_pc;
    prediction_t head_pred;
    logic [past_branch_bits-1:0] head_hist;

    assign head_pc   = pc_mem[rd_ptr];
    assign head_pred = pred_mem[rd_ptr];
    assign head_hist = hist_mem[rd_ptr];

    assign bus.fetch_ready   = (count != cnt_w'(depth));
    assign bus.past_branches = ghr;

    // Predicted direction is the counter's MSB (wt/st); a wrong pop flushes and wins over a push.
    assign pop         = bus.resolve_valid && (count != '0);
    assign pop_correct = (bus.resolve_taken == head_pred[1]);
    assign flush       = pop && !pop_correct;
    assign push        = bus.fetch_valid && bus.fetch_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + cnt_w'(1);
        end else if (pop && !push) begin
            count_next = count - cnt_w'(1);
        end
    end

    // Record storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.fetch_pc;
            pred_mem[wr_ptr] <= bus.fetch_prediction;
            hist_mem[wr_ptr] <= ghr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ghr    <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ghr    <= {head_hist[past_branch_bits-2:0], bus.resolve_taken};
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_w'(1);
                    ghr    <= {ghr[past_branch_bits-2:0], bus.fetch_prediction[1]};
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_w'(1);
                end
            end
        end
    end

    // Table training outputs: strobes pulse for one cycle, data holds between pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.update              <= 1'b0;
            bus.mispredict          <= 1'b0;
            bus.correct             <= 1'b0;
            bus.pc_update           <= '0;
            bus.calculated_target   <= '0;
            bus.update_history      <= '0;
            bus.previous_prediction <= snt;
        end else begin
            bus.update     <= pop;
            bus.mispredict <= flush;
            if (pop) begin
                bus.correct             <= pop_correct;
                bus.pc_update           <= head_pc;
                bus.previous_prediction <= head_pred;
                bus.update_history      <= head_hist;
                bus.calculated_target   <= bus.resolve_taken ? bus.resolve_target
                                                             : head_pc + 32'd4;
            end
        end
    end

`ifdef BHU_STATS_EN
    logic [31:0] resolve_cnt;
    logic [31:0] mispredict_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolve_cnt    <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (pop && (resolve_cnt != '1)) begin
                resolve_cnt <= resolve_cnt + 32'd1;
            end
            if (flush && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

    assign bus.resolve_count    = resolve_cnt;
    assign bus.mispredict_count = mispredict_cnt;
`else
    assign bus.resolve_count    = '0;
    assign bus.mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_history_unit.sv
// Directed, self-checking bench for branch_history_unit (depth 4, 2-bit history).
module tb_branch_history_unit;
    import branch_history_unit_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    branch_history_unit_if #(.past_branch_bits(2)) bus ();

    branch_history_unit #(.past_branch_bits(2), .depth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1ns after the rising edge.
    task automatic drive(input logic fv, input logic [31:0] pc, input prediction_t pr,
                         input logic rv, input logic rt, input logic [31:0] tgt);
        bus.fetch_valid      = fv;
        bus.fetch_pc         = pc;
        bus.fetch_prediction = pr;
        bus.resolve_valid    = rv;
        bus.resolve_taken    = rt;
        bus.resolve_target   = tgt;
        @(posedge clk);
        #1;
        bus.fetch_valid   = 1'b0;
        bus.resolve_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input prediction_t pr);
        drive(1'b1, pc, pr, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        drive(1'b0, 32'h0, snt, 1'b1, taken, tgt);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, snt, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.fetch_valid      = 1'b0;
        bus.fetch_pc         = '0;
        bus.fetch_prediction = snt;
        bus.resolve_valid    = 1'b0;
        bus.resolve_taken    = 1'b0;
        bus.resolve_target   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_update",     32'(bus.update), 32'd0);
        check_eq("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check_eq("rst_ghr",        32'(bus.past_branches), 32'd0);
        check_eq("rst_ready",      32'(bus.fetch_ready), 32'd1);
        check_eq("rst_prevpred",   32'(bus.previous_prediction), 32'(snt));
        check_eq("rst_pc_update",  bus.pc_update, 32'h0);
        check_eq("rst_target",     bus.calculated_target, 32'h0);
        check_eq("rst_res_cnt",    bus.resolve_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single correctly predicted taken branch
        push(32'h100, wt);
        check_eq("p1_ghr", 32'(bus.past_branches), 32'h1);
        check_eq("p1_noupd", 32'(bus.update), 32'd0);
        resolve(1'b1, 32'h200);
        check_eq("p1_update",  32'(bus.update), 32'd1);
        check_eq("p1_correct", 32'(bus.correct), 32'd1);
        check_eq("p1_pc",      bus.pc_update, 32'h100);
        check_eq("p1_target",  bus.calculated_target, 32'h200);
        check_eq("p1_hist",    32'(bus.update_history), 32'h0);
        check_eq("p1_prev",    32'(bus.previous_prediction), 32'(wt));
        check_eq("p1_mp",      32'(bus.mispredict), 32'd0);
        idle();
        check_eq("p1_pulse_end", 32'(bus.update), 32'd0);
        check_eq("p1_pc_hold",   bus.pc_update, 32'h100);

        // Fill to depth, drop a fifth push, then drain in order
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), st);
        check_eq("full_ready", 32'(bus.fetch_ready), 32'd0);
        push(32'h20, snt);
        check_eq("full_drop_ghr", 32'(bus.past_branches), 32'h3);
        resolve(1'b1, 32'h500);
        check_eq("pop1_ready", 32'(bus.fetch_ready), 32'd1);
        check_eq("pop1_pc",    bus.pc_update, 32'h10);
        check_eq("pop1_hist",  32'(bus.update_history), 32'h1);
        for (int i = 1; i < 4; i++) begin
            resolve(1'b1, 32'h500);
            check_eq("drain_pc",  bus.pc_update, 32'h10 + 32'(4 * i));
            check_eq("drain_upd", 32'(bus.update), 32'd1);
        end
        resolve(1'b1, 32'h600);
        check_eq("empty_noupd", 32'(bus.update), 32'd0);
        check_eq("empty_pc",    bus.pc_update, 32'h1C);

        // Mispredict flush with a second entry queued and a simultaneous push
        push(32'h50, snt);
        resolve(1'b0, 32'h0);
        check_eq("pre_ghr", 32'(bus.past_branches), 32'h2);
        push(32'h40, snt);
        push(32'h44, st);
        drive(1'b1, 32'h60, st, 1'b1, 1'b1, 32'h300);
        check_eq("mp_pulse",   32'(bus.mispredict), 32'd1);
        check_eq("mp_update",  32'(bus.update), 32'd1);
        check_eq("mp_correct", 32'(bus.correct), 32'd0);
        check_eq("mp_pc",      bus.pc_update, 32'h40);
        check_eq("mp_hist",    32'(bus.update_history), 32'h2);
        check_eq("mp_target",  bus.calculated_target, 32'h300);
        check_eq("mp_ghr",     32'(bus.past_branches), 32'h1);
        check_eq("mp_ready",   32'(bus.fetch_ready), 32'd1);
        resolve(1'b1, 32'h0);
        check_eq("mp_one_cycle", 32'(bus.mispredict), 32'd0);
        check_eq("flush_empty",  32'(bus.update), 32'd0);

        // Simultaneous push and pop at count 2
        push(32'h70, wt);
        push(32'h74, snt);
        check_eq("sim_pre_ghr", 32'(bus.past_branches), 32'h2);
        drive(1'b1, 32'h7C, wnt, 1'b1, 1'b1, 32'h900);
        check_eq("sim_pc",    bus.pc_update, 32'h70);
        check_eq("sim_ghr",   32'(bus.past_branches), 32'h0);
        check_eq("sim_mp",    32'(bus.mispredict), 32'd0);
        resolve(1'b0, 32'h0);
        check_eq("sim_pc2",   bus.pc_update, 32'h74);
        check_eq("sim_tgt2",  bus.calculated_target, 32'h78);
        resolve(1'b0, 32'h0);
        check_eq("sim_pc3",   bus.pc_update, 32'h7C);
        check_eq("sim_tgt3",  bus.calculated_target, 32'h80);
        check_eq("sim_hist3", 32'(bus.update_history), 32'h2);
        check_eq("sim_prev3", 32'(bus.previous_prediction), 32'(wnt));
        resolve(1'b0, 32'h0);
        check_eq("sim_empty", 32'(bus.update), 32'd0);

        // Asynchronous reset with records in flight
        push(32'h90, st);
        push(32'h94, st);
        push(32'h98, st);
        drive(1'b1, 32'h9C, st, 1'b1, 1'b1, 32'hA00);
        check_eq("pre_rst_upd", 32'(bus.update), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_update", 32'(bus.update), 32'd0);
        check_eq("arst_pc",     bus.pc_update, 32'h0);
        check_eq("arst_target", bus.calculated_target, 32'h0);
        check_eq("arst_ghr",    32'(bus.past_branches), 32'h0);
        check_eq("arst_ready",  32'(bus.fetch_ready), 32'd1);
        check_eq("arst_prev",   32'(bus.previous_prediction), 32'(snt));
        @(negedge clk);
        rst = 1'b0;
        resolve(1'b1, 32'h0);
        check_eq("post_rst_noupd", 32'(bus.update), 32'd0);

        // Statistics: three resolves, one of them mispredicted
        push(32'hA0, st);
        resolve(1'b1, 32'h0);
        push(32'hA4, st);
        resolve(1'b0, 32'h0);
        check_eq("st_mp", 32'(bus.mispredict), 32'd1);
        push(32'hA8, wt);
        resolve(1'b1, 32'h0);
        check_eq("st_mp_clear", 32'(bus.mispredict), 32'd0);
`ifdef BHU_STATS_EN
        check_eq("st_resolves",    bus.resolve_count, 32'd3);
        check_eq("st_mispredicts", bus.mispredict_count, 32'd1);
`else
        check_eq("st_resolves",    bus.resolve_count, 32'd0);
        check_eq("st_mispredicts", bus.mispredict_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_history_unit.md
BRANCH_HISTORY_UNIT -- requirements
Module: branch_history_unit

Interface
REQ-001 Parameter past_branch_bits, default 2, global history width; matches the predictor table's history width.
REQ-002 Parameter depth, default 4, number of in-flight branch records; power of two, 2 to 16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 fetch_valid  input  1  fetch issues a predicted branch this cycle.
REQ-006 fetch_pc  input  32  PC of the issued branch.
REQ-007 fetch_prediction  input  prediction_t  2-bit counter state read from the table for this branch.
REQ-008 fetch_ready  output  1  record buffer can accept a push (not full).
REQ-009 resolve_valid  input  1  execute resolved the oldest in-flight branch.
REQ-010 resolve_taken  input  1  actual branch direction.
REQ-011 resolve_target  input  32  computed taken target.
REQ-012 past_branches  output  past_branch_bits  speculative global history, for table lookup.
REQ-013 update, correct  output  1 each  table write strobe, and direction-correct flag.
REQ-014 pc_update, calculated_target  output  32 each  table write PC and write target.
REQ-015 previous_prediction  output  prediction_t  counter state to be trained.
REQ-016 update_history  output  past_branch_bits  history snapshot for the table write index.
REQ-017 mispredict  output  1  one-cycle flush pulse to fetch.
REQ-018 mispredict_count, resolve_count  output  32 each  statistics (see Configuration).

Function
REQ-019 Record buffer is an in-order FIFO of depth entries; each entry holds {pc, prediction, history snapshot taken before the shift}.
REQ-020 Push: fetch_valid && fetch_ready && !flush stores the entry.
REQ-020a Push also shifts the speculative history as ghr <= {ghr[past_branch_bits-2:0], pred_taken}, with pred_taken = (prediction is wt or st).
REQ-021 fetch_ready = (count != depth); a fetch_valid while full is dropped and the history is unchanged.
REQ-022 Pop: resolve_valid with count != 0 pops the head entry; resolve_valid with count == 0 is ignored (no update, no pulse).
REQ-023 Pop outputs are registered; exactly 1 cycle after the pop, update = 1 for one cycle with:
- pc_update = entry pc
- previous_prediction = entry prediction
- update_history = entry snapshot
- correct = (resolve_taken == pred_taken)
REQ-024 calculated_target = resolve_target when taken, else entry pc + 4 (32-bit wrap).
REQ-025 Mispredict (!correct on a pop):
- same cycle (flush): FIFO is emptied and any simultaneous push is discarded.
- ghr <= {snapshot[past_branch_bits-2:0], resolve_taken}.
- registered outputs: mispredict = 1 for exactly one cycle, coincident with update.
REQ-026 Simultaneous push and pop without mispredict: count is unchanged, both take effect, and the ghr shift applies from the push.
REQ-027 Pointers wrap modulo depth; count ranges 0 to depth.
REQ-028 When not updating, update and mispredict = 0; data outputs hold their last values.

Reset
REQ-029 Reset sets: count = 0, pointers = 0, ghr = 0, update = 0, mispredict = 0, correct = 0, pc_update = 0, calculated_target = 0, update_history = 0, previous_prediction = snt, and both counters = 0.
REQ-030 Reset asserted mid-operation discards all in-flight records immediately; no update pulse is produced for them.

Configuration
REQ-031 Macro BHU_STATS_EN:
- defined: resolve_count increments on every pop and mispredict_count on every mispredict; both saturate at 0xFFFFFFFF.
- undefined: both ports are driven 0 and no counter flops exist.

Verification
REQ-032 Push pc 0x100 with wt, ghr 00 -> past_branches 01; resolve taken, target 0x200 -> next cycle update=1, correct=1, pc_update=0x100, calculated_target=0x200, update_history=00.
REQ-033 Push 4 records (depth 4) -> fetch_ready=0; a 5th push is ignored; pop 1 -> fetch_ready=1.
REQ-034 Push pc 0x40 with snt (snapshot 10), resolve taken -> mispredict=1 and update=1 for one cycle, correct=0, count=0, past_branches=01.
REQ-035 Simultaneous push and pop with correct prediction at count 2 -> count stays 2 and FIFO order is preserved; resolve not-taken for pc 0x7C -> calculated_target=0x80.
REQ-036 resolve_valid on an empty FIFO -> no update; assert rst with 3 records in flight -> all outputs reach reset values without a clock edge; with BHU_STATS_EN, 3 resolves with 1 mispredict -> resolve_count=3, mispredict_count=1.
